// File: rtl/postproc_sequencer.sv
// Streams accumulator beats through the external bias/activation processor and
// buffers its results in a first-word-fall-through FIFO for the downstream writer.
module postproc_sequencer #(
  parameter int CH_W       = 8,
  parameter int PIX_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic [PIX_W-1:0] cfg_num_pix,
  input  logic             cfg_bias_en,
  input  logic [1:0]       cfg_act,
  output logic             busy,
  output logic             done,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [31:0]      acc_data,
  output logic             bias_rd_en,
  output logic [CH_W-1:0]  bias_addr,
  input  logic [31:0]      bias_data,
  output logic [31:0]      op_result_in,
  output logic             op_bias_en,
  output logic [31:0]      op_bias_in,
  output logic [1:0]       op_activation_type,
  input  logic [31:0]      op_result_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t state_reg, state_next;

  logic [CH_W-1:0]  num_ch_reg, ch_cnt_reg;
  logic [PIX_W-1:0] num_pix_reg, pix_cnt_reg;
  logic             bias_en_reg;
  logic [1:0]       act_reg;
  logic [31:0]      result_reg;
  logic [2:0]       vld_pipe_reg, last_pipe_reg;
  logic [32:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic [SW-1:0] inflight, credit;
  logic          acc_fire, ch_wrap, beat_last, fifo_wr, fifo_rd, fifo_nonempty;
  logic [32:0]   head;

  // Credit counts FIFO occupancy plus beats still inside the processor, so a
  // stalled writer can never cause a pipeline beat to be dropped.
  assign inflight  = SW'(vld_pipe_reg[0]) + SW'(vld_pipe_reg[1]) + SW'(vld_pipe_reg[2]);
  assign credit    = SW'(count_reg) + inflight;
  assign acc_ready = (state_reg == RUN) && (credit < SW'(FIFO_DEPTH));
  assign acc_fire  = acc_valid && acc_ready;

  assign ch_wrap   = (ch_cnt_reg == num_ch_reg - CH_W'(1));
  assign beat_last = ch_wrap && (pix_cnt_reg == num_pix_reg - PIX_W'(1));

  assign bias_rd_en         = acc_fire;
  assign bias_addr          = ch_cnt_reg;
  assign op_result_in       = result_reg;
  assign op_bias_en         = bias_en_reg;
  assign op_bias_in         = bias_data;
  assign op_activation_type = act_reg;

  assign fifo_wr       = vld_pipe_reg[2];
  assign fifo_nonempty = (count_reg != '0);
  assign fifo_rd       = fifo_nonempty && out_ready;
  assign head          = fifo_mem[rd_ptr_reg];
  assign out_valid     = fifo_nonempty;
  assign out_data      = fifo_nonempty ? head[31:0] : '0;
  assign out_last      = fifo_nonempty && head[32];

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    busy       = (state_reg != IDLE);
    unique case (state_reg)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_num_ch == '0 || cfg_num_pix == '0) state_next = FINISH;
          else                                       state_next = RUN;
        end
      end
      RUN: begin
        if (acc_fire && beat_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_rd && head[32] && vld_pipe_reg == '0) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      num_ch_reg    <= '0;
      num_pix_reg   <= '0;
      ch_cnt_reg    <= '0;
      pix_cnt_reg   <= '0;
      bias_en_reg   <= 1'b0;
      act_reg       <= '0;
      result_reg    <= '0;
      vld_pipe_reg  <= '0;
      last_pipe_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cfg_start) begin
        num_ch_reg  <= cfg_num_ch;
        num_pix_reg <= cfg_num_pix;
        bias_en_reg <= cfg_bias_en;
        act_reg     <= cfg_act;
        ch_cnt_reg  <= '0;
        pix_cnt_reg <= '0;
      end
      if (acc_fire) begin
        result_reg <= acc_data;
        if (ch_wrap) begin
          ch_cnt_reg  <= '0;
          pix_cnt_reg <= pix_cnt_reg + PIX_W'(1);
        end else begin
          ch_cnt_reg <= ch_cnt_reg + CH_W'(1);
        end
      end
      vld_pipe_reg  <= {vld_pipe_reg[1:0], acc_fire};
      last_pipe_reg <= {last_pipe_reg[1:0], acc_fire && beat_last};
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage only; occupancy is tracked by count_reg so it needs no reset.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_reg] <= {last_pipe_reg[2], op_result_out};
  end

endmodule

// File: tb/tb_postproc_sequencer.sv
// Bench for postproc_sequencer: models the bias RAM and the 2-cycle processor,
// and checks results against a job-level arithmetic reference model.
module tb_postproc_sequencer;
  localparam int CH_W  = 8;
  localparam int PIX_W = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start;
  logic [CH_W-1:0]  cfg_num_ch;
  logic [PIX_W-1:0] cfg_num_pix;
  logic             cfg_bias_en;
  logic [1:0]       cfg_act;
  logic             busy, done;
  logic             acc_valid, acc_ready;
  logic [31:0]      acc_data;
  logic             bias_rd_en;
  logic [CH_W-1:0]  bias_addr;
  logic [31:0]      bias_data;
  logic [31:0]      op_result_in;
  logic             op_bias_en;
  logic [31:0]      op_bias_in;
  logic [1:0]       op_activation_type;
  logic [31:0]      op_result_out;
  logic             out_valid, out_ready, out_last;
  logic [31:0]      out_data;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic signed [31:0] bias_mem [256];
  logic signed [31:0] acc_vals [64];
  logic signed [31:0] bias_q;
  logic signed [31:0] p1, p2;

  postproc_sequencer #(.CH_W(CH_W), .PIX_W(PIX_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix),
    .cfg_bias_en(cfg_bias_en), .cfg_act(cfg_act),
    .busy(busy), .done(done),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .bias_rd_en(bias_rd_en), .bias_addr(bias_addr), .bias_data(bias_data),
    .op_result_in(op_result_in), .op_bias_en(op_bias_en), .op_bias_in(op_bias_in),
    .op_activation_type(op_activation_type), .op_result_out(op_result_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous bias RAM
  always @(posedge clk) if (bias_rd_en) bias_q <= bias_mem[bias_addr];
  assign bias_data = bias_q;

  // Output processor: add stage then activation stage
  always @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= op_result_in + (op_bias_en ? op_bias_in : 32'd0);
      p2 <= (op_activation_type == 2'b01 && p1[31]) ? 32'sd0 : p1;
    end
  end
  assign op_result_out = p2;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_acc_ready"}, acc_ready, 0);
    check_eq({pfx, "_bias_rd_en"}, bias_rd_en, 0);
    check_eq({pfx, "_out_valid"}, out_valid, 0);
    check_eq({pfx, "_out_last"}, out_last, 0);
    check_eq({pfx, "_op_bias_en"}, op_bias_en, 0);
    check_eq({pfx, "_op_result_in"}, op_result_in, 0);
    check_eq({pfx, "_bias_addr"}, bias_addr, 0);
    check_eq({pfx, "_op_act"}, op_activation_type, 0);
    check_eq({pfx, "_out_data"}, out_data, 0);
  endtask

  // vmode/rmode: 0 = always asserted, 1 = random; stall = initial cycles with
  // out_ready low; poke = issue a cfg_start in the middle of the job.
  task automatic run_job(input int nch, input int npix, input bit ben, input bit [1:0] act,
                         input int vmode, input int rmode, input int stall, input bit poke);
    logic signed [31:0] v;
    logic [31:0] exp_q[$];
    logic [31:0] prev_data;
    bit  prev_last, prev_hold, poked, ready_seen, stall_ready;
    int  nb, n, sent, got, start_cyc, fire_first, fire_last, nfire_stall;
    int  first_vld, last_hs, done_cyc, done_n;

    nb = nch * npix;
    for (int i = 0; i < nb; i++) begin
      v = acc_vals[i] + (ben ? bias_mem[i % nch] : 32'sd0);
      if (act == 2'b01 && v < 0) v = 0;
      exp_q.push_back(v);
    end
    n = 0; sent = 0; got = 0; fire_first = -1; fire_last = -1; nfire_stall = 0;
    first_vld = -1; last_hs = -1; done_cyc = -1; done_n = 0;
    prev_hold = 0; prev_data = '0; prev_last = 0; poked = 0; ready_seen = 0; stall_ready = 0;

    @(negedge clk);
    cfg_num_ch = CH_W'(nch); cfg_num_pix = PIX_W'(npix);
    cfg_bias_en = ben; cfg_act = act; cfg_start = 1'b1;
    start_cyc = cyc;

    while (n < 2000 && !(done_cyc >= 0 && cyc >= done_cyc + 2)) begin
      @(negedge clk);
      n++;
      if (poke && !poked && sent == 2) begin
        cfg_start = 1'b1; cfg_num_pix = '0; cfg_num_ch = 8'd1; cfg_act = ~act;
        poked = 1;
      end else begin
        cfg_start = 1'b0;
      end
      acc_valid = (sent < nb) && (vmode == 0 || $urandom_range(0, 9) < 7);
      acc_data  = (sent < nb) ? acc_vals[sent] : 32'd0;
      out_ready = (n <= stall) ? 1'b0 : (rmode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      #1;
      if (prev_hold) begin
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_last", out_last, prev_last);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (acc_ready) ready_seen = 1;
      if (n == stall) stall_ready = acc_ready;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (acc_valid && acc_ready) begin
        check_eq("bias_rd_en", bias_rd_en, 1);
        check_eq("bias_addr", bias_addr, sent % nch);
        check_eq("op_bias_en", op_bias_en, ben);
        check_eq("op_act", op_activation_type, act);
        if (fire_first < 0) fire_first = cyc;
        fire_last = cyc;
        if (n <= stall) nfire_stall++;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_result", out_data, 32'hDEAD_BEEF);
        end else begin
          check_eq($sformatf("data[%0d]", got), out_data, exp_q.pop_front());
          check_eq($sformatf("last[%0d]", got), out_last, (got == nb - 1));
        end
        last_hs = cyc;
        got++;
      end
    end
    acc_valid = 1'b0;

    check_eq("done_pulses", done_n, 1);
    check_eq("result_count", got, nb);
    check_eq("busy_after", busy, 0);
    if (nb > 0) check_eq("done_after_last", done_cyc - last_hs, 1);
    else begin
      check_eq("empty_done_window", (done_cyc - start_cyc >= 1 && done_cyc - start_cyc <= 2), 1);
      check_eq("empty_acc_ready", ready_seen, 0);
    end
    if (nb > 0 && vmode == 0 && rmode == 0 && stall == 0) begin
      check_eq("consecutive", fire_last - fire_first, nb - 1);
      check_eq("latency", first_vld - (fire_first + 1), 3);
    end
    if (stall > 0) begin
      check_eq("stall_accepts", nfire_stall, DEPTH);
      check_eq("stall_acc_ready", stall_ready, 0);
    end
    $display("job nch=%0d npix=%0d bias=%0d act=%0d: %0d beats, %0d results", nch, npix, ben, act, sent, got);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_num_ch = '0; cfg_num_pix = '0;
    cfg_bias_en = 1'b0; cfg_act = '0; acc_valid = 1'b0; acc_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) bias_mem[i] = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    bias_mem[0] = 10; bias_mem[1] = -20;
    acc_vals[0] = 5; acc_vals[1] = 30; acc_vals[2] = -30; acc_vals[3] = 1;
    run_job(2, 2, 1, 2'b01, 0, 0, 0, 0);
    run_job(2, 2, 1, 2'b00, 0, 0, 0, 0);

    acc_vals[0] = 7; acc_vals[1] = -7;
    run_job(2, 1, 0, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) bias_mem[i] = $signed($urandom_range(0, 2000)) - 1000;
    for (int i = 0; i < 30; i++) acc_vals[i] = $urandom;
    run_job(3, 10, 1, 2'b01, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) acc_vals[i] = $urandom;
    run_job(4, 4, 1, 2'b00, 0, 0, 20, 0);

    bias_mem[0] = 1; acc_vals[0] = 32'h7FFF_FFFF;
    run_job(1, 1, 1, 2'b00, 0, 0, 0, 0);
    run_job(1, 1, 1, 2'b01, 0, 0, 0, 0);

    run_job(3, 0, 1, 2'b00, 0, 0, 0, 0);
    run_job(0, 5, 1, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) acc_vals[i] = $urandom;
    run_job(2, 3, 1, 2'b01, 1, 1, 0, 1);

    // Reset in the middle of a stalled job
    @(negedge clk);
    cfg_num_ch = 8'd2; cfg_num_pix = 16'd4; cfg_bias_en = 1'b1; cfg_act = 2'b01; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; acc_valid = 1'b1; acc_data = 32'h1234; out_ready = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("busy_mid_job", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0; acc_valid = 1'b0;
    for (int i = 0; i < 8; i++) acc_vals[i] = $urandom;
    run_job(2, 4, 1, 2'b01, 0, 0, 0, 0);

    for (int j = 0; j < 8; j++) begin
      int nch, npix;
      nch  = $urandom_range(1, 4);
      npix = $urandom_range(1, 6);
      for (int i = 0; i < nch; i++) bias_mem[i] = $urandom;
      for (int i = 0; i < nch * npix; i++) acc_vals[i] = $urandom;
      run_job(nch, npix, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1, 1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/postproc_sequencer.md
Name: postproc_sequencer

Overview:
Controller that streams accumulator results through the bias/activation output processor for one layer job.
- Latches a job configuration: channel count, pixel count, bias enable, activation.
- Accepts accumulator beats, fetches the per-channel bias from a synchronous bias RAM, and drives the output processor.
- Tracks the processor's fixed pipeline latency.
- Buffers results in a small FIFO so the downstream writer can apply backpressure, which the processor itself cannot absorb.

Parameters:
- CH_W, 8, width of channel count/index (max 2^CH_W-1 channels)
- PIX_W, 16, width of pixel count
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >=5 for full throughput)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_start  in  1  start-job pulse; sampled only in IDLE
- cfg_num_ch  in  CH_W  channels per pixel
- cfg_num_pix  in  PIX_W  pixels in job
- cfg_bias_en  in  1  bias enable for job
- cfg_act  in  2  activation code (00 linear, 01 ReLU, others linear)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- acc_valid  in  1  accumulator beat valid
- acc_ready  out  1  accumulator beat accepted when valid&ready
- acc_data  in  32  signed accumulator value, channel-fastest order
- bias_rd_en  out  1  bias RAM read strobe
- bias_addr  out  CH_W  bias RAM address = current channel index
- bias_data  in  32  signed bias, valid the cycle after bias_rd_en
- op_result_in  out  32  to processor result input (registered)
- op_bias_en  out  1  to processor bias enable (latched cfg)
- op_bias_in  out  32  to processor bias input (= bias_data)
- op_activation_type  out  2  to processor activation (latched cfg)
- op_result_out  in  32  from processor; 2-cycle latency from its inputs
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts when valid&ready
- out_data  out  32  signed result
- out_last  out  1  marks final result of job

Behaviour:
- Reset values:
  - Outputs: busy, done, acc_ready, bias_rd_en, out_valid, out_last, op_bias_en all 0; op_result_in, bias_addr, op_activation_type, out_data all 0.
  - Internal state: FIFO empty, valid pipe cleared, counters 0, state IDLE.
- Reset mid-job: in-flight beats and FIFO contents are discarded; done is not pulsed. The processor shares rst.
- States:
  - IDLE:
    - On cfg_start, latch cfg_* and clear ch_cnt/pix_cnt.
    - If cfg_num_ch==0 or cfg_num_pix==0, go to FINISH with no beats.
    - Otherwise go to RUN.
  - RUN: accept beats. After the beat with ch_cnt==num_ch-1 and pix_cnt==num_pix-1 is accepted, go to DRAIN.
  - DRAIN: wait until the valid pipe is empty and the FIFO has been emptied by the out_last handshake, then go to FINISH.
  - FINISH: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, DRAIN and FINISH. cfg_start outside IDLE is ignored.
- acc_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH). It is combinational from registered state only, never from acc_valid or out_ready. inflight = number of set bits in the 3-stage valid pipe.
- Accept edge E0 (acc_valid&acc_ready):
  - bias_rd_en=1 in the accept cycle, with bias_addr=ch_cnt.
  - op_result_in registers acc_data.
  - ch_cnt increments and wraps to 0 at num_ch-1; pix_cnt increments on wrap.
  - Valid pipe stage0 is set, with a last flag set for the final beat.
- op_bias_in = bias_data, combinational. In the cycle after E0 it aligns with op_result_in.
- The processor captures at E1 and E2; op_result_out is valid after E2.
- The FIFO writes {last, op_result_out} at E3 when pipe stage2 is set.
- The FIFO is first-word-fall-through: out_valid rises the cycle after E3, so latency is 3 cycles from accept edge to out_valid.
- Throughput: with out_ready held 1 and FIFO_DEPTH>=5, one beat per cycle is sustained with no bubbles.
- Backpressure: out_ready may drop at any time. out_data/out_last hold stable while out_valid&!out_ready. The credit rule guarantees no FIFO overflow and no lost pipeline beats.
- Simultaneous FIFO write and read: both occur; count unchanged.
- Arithmetic: performed entirely by the processor (32-bit two's-complement wrap, ReLU on bit 31). The controller never modifies data.
- op_bias_en and op_activation_type are constant for the whole job.

Test Plan:
- num_ch=2, num_pix=2, bias RAM [10,-20], acc [5,30,-30,1]:
  - ReLU → out [15,10,0,0].
  - Linear → [15,10,-20,-19].
  - out_last only on 4th beat; done one cycle after that handshake.
- bias_en=0, linear, acc [7,-7] → out [7,-7]. bias_rd_en still toggles; output unaffected.
- num_ch=3, num_pix=10, acc_valid=1, out_ready=1 → 30 beats accepted on 30 consecutive cycles; first out_valid 3 cycles after first accept; busy drops after done.
- out_ready=0 for 20 cycles during a 16-beat job → exactly FIFO_DEPTH beats accepted, then acc_ready=0. After release, all 16 results arrive in order, none lost or duplicated.
- Linear, bias 1, acc 0x7FFFFFFF → out 0x80000000. Same with ReLU → 0.
- Edge cases:
  - num_pix=0 → done pulse 2 cycles after cfg_start; acc_ready never 1.
  - cfg_start while busy → ignored.
  - rst asserted mid-job → all outputs at reset values next cycle; a following job runs correctly.
